// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared state type and constants for the I2C register target
package i2c_target_pkg;
  localparam int CNT_W = 4;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ = 1'b1;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;
endpackage

// File: rtl/i2c_line_monitor.sv
// i2c_line_monitor: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions
module i2c_line_monitor (
  input  logic clk,
  input  logic rstp,
  input  logic Scl_i,
  input  logic Sda_i,
  output logic SclRise,
  output logic SclFall,
  output logic Start,
  output logic Stop,
  output logic SdaSync
);
  logic [2:0] r_scl, r_sda;
  logic w_scl_high;
  always_ff @(posedge clk) begin
    if (rstp) begin
      r_scl <= '1;
      r_sda <= '1;
    end else begin
      r_scl <= {r_scl[1:0], Scl_i};
      r_sda <= {r_sda[1:0], Sda_i};
    end
  end
  // stages 0/1 synchronize, stage 2 is the previous value for edge detection
  assign w_scl_high = r_scl[1] & r_scl[2];
  assign SclRise = r_scl[1] & ~r_scl[2];
  assign SclFall = ~r_scl[1] & r_scl[2];
  assign Start = w_scl_high & r_sda[2] & ~r_sda[1];
  assign Stop = w_scl_high & ~r_sda[2] & r_sda[1];
  assign SdaSync = r_sda[1];
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target serving pointer-addressed byte writes and reads of a register file
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] Address = 7'h20,
  parameter int NumRegs = 8,
  parameter logic [7:0] ResetValue = 8'h00,
  localparam int PtrW = $clog2(NumRegs)
) (
  input  logic                 clk,
  input  logic                 rstp,
  input  logic                 Scl_i,
  input  logic                 Sda_i,
  output logic                 SdaOe_o,
  output logic [NumRegs*8-1:0] Regs_ob,
  output logic                 WrStrobe_o,
  output logic [PtrW-1:0]      WrAddr_ob,
  output logic                 Busy_o
);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0] r_shift;
  logic [PtrW-1:0] r_ptr, r_waddr;
  logic [NumRegs-1:0][7:0] r_regs;
  logic r_oe, r_busy, r_wr, r_rw;
  logic w_rise, w_fall, w_start, w_stop, w_sda, w_last, w_match, w_load;
  logic [7:0] w_byte, w_rd;
  i2c_line_monitor u_mon (
    .clk(clk),
    .rstp(rstp),
    .Scl_i(Scl_i),
    .Sda_i(Sda_i),
    .SclRise(w_rise),
    .SclFall(w_fall),
    .Start(w_start),
    .Stop(w_stop),
    .SdaSync(w_sda)
  );
  assign w_byte = {r_shift, w_sda};
  assign w_rd = r_regs[r_ptr];
  assign w_last = r_cnt == CNT_W'(7);
  assign w_match = r_shift == Address;
  // read byte fetch happens on the SCL fall that closes an ACK slot
  assign w_load = w_fall & (r_state == ST_RDATA_ACK |
                  (r_state == ST_ADDR_ACK & r_oe & r_rw == I2C_RW_READ));
  always_ff @(posedge clk) begin
    if (rstp) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_shift <= '0;
      r_ptr <= '0;
      r_regs <= {NumRegs{ResetValue}};
      r_oe <= 1'b0;
      r_busy <= 1'b0;
      r_wr <= 1'b0;
      r_waddr <= '0;
      r_rw <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (w_start) begin
        r_state <= ST_ADDR;
        r_cnt <= '0;
        r_oe <= 1'b0;
        r_busy <= 1'b0;
      end else if (w_stop) begin
        r_state <= ST_IDLE;
        r_oe <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: if (w_rise) begin
            r_shift <= w_byte[6:0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_rw <= w_sda;
              r_busy <= w_match;
              r_state <= w_match ? ST_ADDR_ACK : ST_IDLE;
            end
          end
          ST_PTR: if (w_rise) begin
            r_shift <= w_byte[6:0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_ptr <= w_byte[PtrW-1:0];
              r_state <= ST_PTR_ACK;
            end
          end
          ST_WDATA: if (w_rise) begin
            r_shift <= w_byte[6:0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_regs[r_ptr] <= w_byte;
              r_wr <= 1'b1;
              r_waddr <= r_ptr;
              r_ptr <= r_ptr + 1'b1;
              r_state <= ST_WDATA_ACK;
            end
          end
          // first fall starts driving ACK, second fall ends the slot
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (w_fall) begin
            r_oe <= ~r_oe;
            if (r_oe) begin
              r_cnt <= '0;
              r_state <= r_state == ST_ADDR_ACK ? ST_PTR : ST_WDATA;
            end
          end
          ST_RDATA: if (w_fall) begin
            if (r_cnt == CNT_W'(8)) begin
              r_oe <= 1'b0;
              r_state <= ST_RDATA_ACK;
            end else begin
              r_oe <= ~r_shift[6];
              r_shift <= {r_shift[5:0], 1'b0};
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_RDATA_ACK: if (w_rise && w_sda) r_state <= ST_IDLE;
          default: ;
        endcase
        if (w_load) begin
          r_shift <= w_rd[6:0];
          r_oe <= ~w_rd[7];
          r_cnt <= CNT_W'(1);
          r_ptr <= r_ptr + 1'b1;
          r_state <= ST_RDATA;
        end
      end
    end
  end
  assign SdaOe_o = r_oe;
  assign Regs_ob = r_regs;
  assign WrStrobe_o = r_wr;
  assign WrAddr_ob = r_waddr;
  assign Busy_o = r_busy;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master against a transaction-level register model
module tb_i2c_target_regs;
  localparam int N = 8;
  localparam int Q = 4;
  localparam logic [6:0] ADDR = 7'h20;
  logic clk = 1'b0, rstp = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  logic sda_line, oe, wr, busy;
  logic [N*8-1:0] regs;
  logic [2:0] waddr;
  int n_tests = 0, n_fail = 0;
  logic [7:0] m_regs [N];
  int m_ptr;
  int wr_q[$];
  logic oe_seen, busy_seen;
  typedef struct {
    logic [6:0] a;
    logic rd;
    logic [7:0] p;
    int n;
    logic [31:0] wd;
    logic ack;
    logic [31:0] rdv;
  } vec_t;
  vec_t tv [8];
  always #5 clk = ~clk;
  assign sda_line = m_sda & ~oe;
  i2c_target_regs #(.Address(ADDR), .NumRegs(N), .ResetValue(8'h00)) dut (
    .clk(clk), .rstp(rstp), .Scl_i(m_scl), .Sda_i(sda_line), .SdaOe_o(oe),
    .Regs_ob(regs), .WrStrobe_o(wr), .WrAddr_ob(waddr), .Busy_o(busy));
  always @(negedge clk) begin
    if (wr) wr_q.push_back(int'(waddr));
    if (oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [N*8-1:0] m_pack();
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[8*i+:8] = m_regs[i];
    return v;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask
  task automatic bit_io(input logic b, output logic s);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q();
    s = sda_line; wait_q();
    m_scl = 1'b0; wait_q();
  endtask
  task automatic start_c();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask
  task automatic stop_c();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(nack, s);
  endtask
  task automatic run_xfer(input logic [6:0] a, input logic rd, input logic [7:0] p, input int n,
                          input logic [31:0] wd, input logic exp_ack, input logic use_exp,
                          input logic [31:0] exp_rd);
    logic k, ack_all, ack_any;
    logic [7:0] d;
    logic [31:0] got, mrd;
    int mp;
    int ew[$];
    wr_q.delete();
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    mrd = '1;
    got = '0;
    if (a == ADDR) begin
      mp = int'(p) % N;
      for (int i = 0; i < n; i++) begin
        if (rd) mrd[8*i+:8] = m_regs[mp];
        else begin
          m_regs[mp] = wd[8*i+:8];
          ew.push_back(mp);
        end
        mp = (mp + 1) % N;
      end
      m_ptr = mp;
    end
    ack_all = 1'b1;
    ack_any = 1'b0;
    start_c();
    write_byte({a, 1'b0}, k); ack_all &= k; ack_any |= k;
    write_byte(p, k); ack_all &= k; ack_any |= k;
    if (rd) begin
      start_c();
      write_byte({a, 1'b1}, k); ack_all &= k; ack_any |= k;
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, d);
        got[8*i+:8] = d;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        write_byte(wd[8*i+:8], k); ack_all &= k; ack_any |= k;
      end
    end
    stop_c();
    chk("ack_all", ack_all, exp_ack);
    chk("ack_any", ack_any, exp_ack);
    if (rd) for (int i = 0; i < n; i++) begin
      chk("rdata_model", got[8*i+:8], mrd[8*i+:8]);
      if (use_exp) chk("rdata_table", got[8*i+:8], exp_rd[8*i+:8]);
    end
    chk("regs", regs, m_pack());
    chk("wr_count", wr_q.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wr_q.size(); i++) chk("wr_addr", wr_q[i], ew[i]);
    chk("busy_seen", busy_seen, exp_ack);
    chk("oe_seen", oe_seen, exp_ack);
    chk("oe_idle", oe, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask
  initial begin
    logic k;
    logic [6:0] a;
    logic rd;
    tv[0] = '{7'h20, 1'b0, 8'h03, 2, 32'h5AA5, 1'b1, 32'h0};
    tv[1] = '{7'h20, 1'b0, 8'h07, 1, 32'hC3, 1'b1, 32'h0};
    tv[2] = '{7'h20, 1'b1, 8'h07, 2, 32'h0, 1'b1, 32'h00C3};
    tv[3] = '{7'h21, 1'b0, 8'h11, 0, 32'h0, 1'b0, 32'h0};
    tv[4] = '{7'h20, 1'b1, 8'h03, 3, 32'h0, 1'b1, 32'h005AA5};
    tv[5] = '{7'h20, 1'b0, 8'h06, 3, 32'h332211, 1'b1, 32'h0};
    tv[6] = '{7'h20, 1'b1, 8'h07, 2, 32'h0, 1'b1, 32'h3322};
    tv[7] = '{7'h21, 1'b1, 8'h00, 1, 32'h0, 1'b0, 32'hFF};
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_oe", oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_waddr", waddr, 3'd0);
    chk("rst_regs", regs, m_pack());
    rstp = 1'b0;
    wait_q();
    for (int i = 0; i < 8; i++)
      run_xfer(tv[i].a, tv[i].rd, tv[i].p, tv[i].n, tv[i].wd, tv[i].ack, 1'b1, tv[i].rdv);
    // STOP four bits into a data byte must not write anything
    wr_q.delete();
    start_c();
    write_byte({ADDR, 1'b0}, k);
    write_byte(8'h05, k);
    m_ptr = 5;
    for (int i = 0; i < 4; i++) bit_io(i[0], k);
    stop_c();
    chk("abort_wr", wr_q.size(), 0);
    chk("abort_oe", oe, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_regs", regs, m_pack());
    run_xfer(ADDR, 1'b0, 8'h05, 2, 32'h9C4E, 1'b1, 1'b0, 32'h0);
    run_xfer(ADDR, 1'b1, 8'h04, 3, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int t = 0; t < 30; t++) begin
      a = ($urandom_range(0, 7) == 0) ? (ADDR ^ 7'(1 << $urandom_range(0, 6))) : ADDR;
      rd = 1'($urandom_range(0, 1));
      run_xfer(a, rd, 8'($urandom), int'($urandom_range(1, 4)), $urandom, a == ADDR, 1'b0, 32'h0);
    end
    // reset while the target drives a 0 data bit
    run_xfer(ADDR, 1'b0, 8'h01, 1, 32'h12, 1'b1, 1'b0, 32'h0);
    start_c();
    write_byte({ADDR, 1'b0}, k);
    write_byte(8'h01, k);
    start_c();
    write_byte({ADDR, 1'b1}, k);
    chk("rd_drive", oe, 1'b1);
    rstp = 1'b1;
    @(negedge clk);
    chk("rst_mid_oe", oe, 1'b0);
    chk("rst_mid_regs", regs, {N{8'h00}});
    rstp = 1'b0;
    m_reset();
    stop_c();
    run_xfer(ADDR, 1'b1, 8'h01, 1, 32'h0, 1'b1, 1'b1, 32'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Synthesizable I2C target (slave) with a small register file, the responder counterpart to the on-board I2C master/reader chain used by the diagnostics path. It oversamples SCL/SDA on the system clock, detects START/STOP, acknowledges its 7-bit address, and serves pointer-addressed byte writes and reads. It is used in-system as an FPGA-side register target and in benches as the device model the diagnostics master talks to.

## Interface
- Address, 7'h20, 7-bit target address answered.
- NumRegs, 8, register count; power of two, 2..256; PtrW = $clog2(NumRegs).
- ResetValue, 8'h00, reset contents of every register.

- clk  in  1  system clock; ≥ 16× SCL frequency.
- rstp  in  1  synchronous active-high reset.
- Scl_i  in  1  SCL pad input, asynchronous.
- Sda_i  in  1  SDA pad input, asynchronous.
- SdaOe_o  out  1  1 = pull SDA low; 0 = release. Top level ties the pad output to 0.
- Regs_ob  out  NumRegs*8  register file, reg k at bits [8k+7:8k].
- WrStrobe_o  out  1  one-cycle pulse when a register is written.
- WrAddr_ob  out  PtrW  index written, valid with WrStrobe_o.
- Busy_o  out  1  high from address match to STOP/START/mismatch.

## Operation
- Line monitor: Scl_i/Sda_i pass 2-FF sync, then a third stage for edge detect. SclRise/SclFall from stages 2/3. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START (incl. repeated) from any state -> ADDR, bit counter 0, SdaOe_o released. STOP from any state -> IDLE, release.
- ADDR: shift SDA MSB-first on SclRise; 8 bits. Match [7:1]==Address -> ADDR_ACK; mismatch -> IDLE (no ACK, ignore until next START).
- ACK slot: SdaOe_o=1 from SclFall after bit 8 until next SclFall.
- After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA.
- PTR: received byte, low PtrW bits -> pointer; ACK; -> WDATA.
- WDATA: byte written to reg[ptr] at SclRise of bit 8 (WrStrobe_o pulses, WrAddr_ob=ptr); ptr increments mod NumRegs; ACK; repeat.
- RDATA: on the SclFall ending the ADDR_ACK/previous ACK slot, load shifter from reg[ptr], ptr increments mod NumRegs; drive SdaOe_o = ~bit (MSB first) on each SclFall. After bit 8, release for master ACK; sample on SclRise in RDATA_ACK: 0 -> next byte; 1 (NACK) -> IDLE-wait (release, ignore until START/STOP).
- Pointer persists across transactions (write-pointer-then-repeated-start-read supported); reset clears it to 0.
- Reset: SdaOe_o=0, Busy_o=0, WrStrobe_o=0, WrAddr_ob=0, ptr=0, all regs=ResetValue, state IDLE. Reset mid-transfer releases SDA the next cycle.

## Timing
- Input-to-detect latency: 3 clk from pad edge to SclRise/SclFall/START/STOP pulse.
- SdaOe_o changes exactly 1 clk after the SclFall pulse (SDA hold after SCL low guaranteed); never changes while synced SCL is high.
- WrStrobe_o asserted 1 clk after SclRise of 8th data bit; Regs_ob updated same cycle.
- START and STOP detection take priority over a coincident SCL edge.

## Structure
- Package i2c_target_pkg: state enum typedef, I2C_RW_READ/WRITE constants, bit-count width.
- Sub-module i2c_line_monitor: synchronizers, edge and START/STOP detection; outputs SclRise, SclFall, Start, Stop, SdaSync.

## Test plan
- Write: START, 0x40, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK each byte; reg3=0xA5, reg4=0x5A; two WrStrobe_o pulses, WrAddr_ob 3 then 4.
- Read with repeated start: write ptr 0x07, Sr, 0x41, read 2 bytes (ACK, NACK) -> returns reg7, reg0 (wrap); SDA released after NACK.
- Address mismatch: START, 0x42, 0x11 -> no ACK, SdaOe_o never 1, registers unchanged, Busy_o stays 0.
- Abort: STOP after 4 bits of a data byte -> no write, IDLE, SdaOe_o=0; following transaction works.
- Reset mid-read while driving 0 -> SdaOe_o=0 next clk, regs=ResetValue, ptr=0.
- Closed loop: diagnostics master at divider 10'h3ff against this target at 0x20 -> sequence completes, done asserted, read-back data matches.
